spi_slave_sync: RTL and testbench

Fully synchronous, parametrised SPI slave: the successor to the async-clocked SPI slave. All SPI pins are oversampled in the `i_clk` domain, so no logic is clocked by `i_sck`. Supports configurable frame width and all four CPOL/CPHA modes. Adds a ready/valid TX holding register, a single-cycle RX valid strobe, and back-to-back frames within one chip-select. It sits between the external SPI master pins and the register/status logic of the CPLD.

---
 rtl/spi_slave_sync.sv | 139 +++++++++++++
 tb/tb_spi_slave_sync.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// Fully synchronous SPI slave: SCK/SSEL/MOSI oversampled in i_clk, all CPOL/CPHA modes, back-to-back frames.
// Optional: define SPI_SLAVE_SYNC_FRAME_ERR_EN to add o_frame_err (abort / underrun pulse).
module spi_slave_sync #(
    parameter int FRAME_BITS  = 16,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy,
    output logic                  o_miso,
    output logic                  o_miso_oe,
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    output logic                  o_frame_err,
`endif
    input  logic                  i_ssel_n,
    input  logic                  i_mosi,
    input  logic                  i_sck
);
    localparam int   CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic SCK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sck_sync, ssel_sync, mosi_sync;
    logic                    sck_dly, ssel_dly;
    logic                    sck_s, ssel_s, mosi_s;
    logic                    sck_rise, sck_fall, ssel_fall;
    logic                    sample_edge, shift_edge, cnt_last;
    logic                    reload, done, sample_en, shift_en, cnt_clr;
    logic [CNT_W-1:0]        cnt;
    logic                    hold_full;
    logic [FRAME_BITS-1:0]   hold_data, tx_shift, rx_shift;

    // Synchroniser stage: reset to the bus idle levels so no edge is seen on release
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            ssel_sync <= '1;
            mosi_sync <= '0;
            sck_dly   <= SCK_IDLE;
            ssel_dly  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_sck};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], i_ssel_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sck_dly   <= sck_sync[SYNC_STAGES-1];
            ssel_dly  <= ssel_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign ssel_s      = ssel_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_dly;
    assign sck_fall    = ~sck_s & sck_dly;
    assign ssel_fall   = ~ssel_s & ssel_dly;
    assign sample_edge = ((CPOL != 0) ^ (CPHA != 0)) ? sck_fall : sck_rise;
    assign shift_edge  = ((CPOL != 0) ^ (CPHA != 0)) ? sck_rise : sck_fall;
    assign cnt_last    = (cnt == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ssel_fall) state_nxt = LOAD;
            LOAD:    state_nxt = ssel_s ? IDLE : SHIFT;
            SHIFT: begin
                if (sample_edge && cnt_last) state_nxt = DONE;
                else if (ssel_s)             state_nxt = IDLE;
            end
            DONE:    state_nxt = ssel_s ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    // A shift edge with cnt==0 is either the CPHA=1 first leading edge or, for CPHA=0,
    // the trailing edge of the previous frame's last bit arriving after the DONE reload.
    always_comb begin
        o_busy    = (state != IDLE);
        reload    = (state == LOAD) || (state == DONE);
        done      = (state == DONE);
        sample_en = (state == SHIFT) && sample_edge;
        shift_en  = (state == SHIFT) && shift_edge && (cnt != '0);
        cnt_clr   = reload || ((state == SHIFT) && (state_nxt == IDLE));
    end

    assign o_tx_ready = ~hold_full;
    assign o_miso_oe  = ~ssel_s;

    // Control / output register stage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            hold_full  <= 1'b0;
            tx_shift   <= '1;
            o_miso     <= 1'b1;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= done;
            if (done) o_rx_data <= rx_shift;
            if (cnt_clr)        cnt <= '0;
            else if (sample_en) cnt <= cnt + CNT_W'(1);
            if (reload)        tx_shift <= hold_full ? hold_data : '1;
            else if (shift_en) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b1};
            if (reload && hold_full)           hold_full <= 1'b0;
            else if (i_tx_valid && !hold_full) hold_full <= 1'b1;
            o_miso <= tx_shift[FRAME_BITS-1];
        end
    end

    // Data registers carry no reset; their contents are only consumed behind hold_full / done
    always_ff @(posedge i_clk) begin
        if (i_tx_valid && !hold_full) hold_data <= i_tx_data;
        if (sample_en)                rx_shift  <= {rx_shift[FRAME_BITS-2:0], mosi_s};
    end

`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    logic abort;
    assign abort = (state == SHIFT) && (state_nxt == IDLE) && (cnt != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) o_frame_err <= 1'b0;
        else       o_frame_err <= abort || (reload && !hold_full);
    end
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: four instances (SPI modes 0..3) driven by a behavioural master.
module tb_spi_slave_sync;
    localparam int FB = 16, S = 2, HP = 8, SETUP = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [FB-1:0] tx_data [4];
    logic          tx_valid[4];
    logic          tx_ready[4];
    logic [FB-1:0] rx_data [4];
    logic          rx_valid[4];
    logic          busy    [4];
    logic          miso    [4];
    logic          miso_oe [4];
    logic          ssel_n  [4];
    logic          mosi    [4];
    logic          sck     [4];
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    logic          ferr    [4];
    int            ferr_cnt[4];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(.FRAME_BITS(FB), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(S)) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_tx_data(tx_data[g]), .i_tx_valid(tx_valid[g]), .o_tx_ready(tx_ready[g]),
            .o_rx_data(rx_data[g]), .o_rx_valid(rx_valid[g]), .o_busy(busy[g]),
            .o_miso(miso[g]), .o_miso_oe(miso_oe[g]),
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
            .o_frame_err(ferr[g]),
`endif
            .i_ssel_n(ssel_n[g]), .i_mosi(mosi[g]), .i_sck(sck[g])
        );
    end

    int            errors = 0, checks = 0;
    logic [FB-1:0] exp_rx[4][$];
    logic [FB-1:0] exp_mi[4][$];
    logic [FB-1:0] got_mi[4][$];
    logic [FB-1:0] pend  [4][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one entry consumed per rx_valid strobe
    task automatic monitor();
        logic [FB-1:0] er, em, gm;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
                if (ferr[m] === 1'b1) ferr_cnt[m]++;
`endif
                if (rx_valid[m] === 1'b1) begin
                    if (exp_rx[m].size() == 0) begin
                        check($sformatf("m%0d unexpected rx_valid", m), rx_valid[m], 0);
                    end else begin
                        er = exp_rx[m].pop_front();
                        em = exp_mi[m].pop_front();
                        gm = (got_mi[m].size() != 0) ? got_mi[m].pop_front() : 'x;
                        check($sformatf("m%0d rx_data", m), rx_data[m], er);
                        check($sformatf("m%0d miso word", m), gm, em);
                    end
                end
            end
        end
    endtask

    task automatic push_tx(input int m, input logic [FB-1:0] w);
        check($sformatf("m%0d tx_ready before push", m), tx_ready[m], 1);
        tx_data[m]  = w;
        tx_valid[m] = 1'b1;
        cyc(1);
        tx_valid[m] = 1'b0;
        pend[m].push_back(w);
    endtask

    task automatic sel_low(input int m);
        ssel_n[m] = 1'b0;
        cyc(SETUP);
    endtask

    task automatic sel_high(input int m);
        cyc(HP);
        ssel_n[m] = 1'b1;
        cyc(HP);
    endtask

    // Master for one frame of nbits; a full frame queues its expected rx word and MISO word
    task automatic xfer(input int m, input logic [FB-1:0] w, input int nbits, input bit do_push,
                        input logic [FB-1:0] pw, input int rst_bit, output bit reset_hit);
        logic          cpol, cpha;
        logic [FB-1:0] cap, em;
        cpol = (m >= 2);
        cpha = (m % 2) == 1;
        cap  = '0;
        em   = (pend[m].size() != 0) ? pend[m].pop_front() : '1;
        reset_hit = 1'b0;
        if (!cpha) mosi[m] = w[FB-1];
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1; ssel_n[m] = 1'b1; sck[m] = cpol; mosi[m] = 1'b0;
                cyc(1);
                rst = 1'b0;
                pend[m].delete();
                reset_hit = 1'b1;
                return;
            end
            if (do_push && i == 1) begin
                push_tx(m, pw);
                cyc(HP - 1);
            end else begin
                cyc(HP);
            end
            sck[m] = ~cpol;
            if (cpha) mosi[m] = w[FB-1-i];
            else      cap = {cap[FB-2:0], miso[m]};
            if (!cpha && i == FB - 1 && nbits == FB) begin
                exp_rx[m].push_back(w); exp_mi[m].push_back(em); got_mi[m].push_back(cap);
            end
            cyc(HP);
            sck[m] = cpol;
            if (cpha) begin
                cap = {cap[FB-2:0], miso[m]};
                if (i == FB - 1 && nbits == FB) begin
                    exp_rx[m].push_back(w); exp_mi[m].push_back(em); got_mi[m].push_back(cap);
                end
            end else if (i < nbits - 1) begin
                mosi[m] = w[FB-2-i];
            end
        end
    endtask

    task automatic run_mode(input int m);
        bit            hit;
        logic [FB-1:0] prev;
        int            n;
        // Directed exchange
        push_tx(m, 16'hA5C3);
        sel_low(m);
        xfer(m, 16'h1234, FB, 0, '0, -1, hit);
        sel_high(m);
        check($sformatf("m%0d tx_ready after frame", m), tx_ready[m], 1);
        check($sformatf("m%0d busy after frame", m), busy[m], 0);
        // Three back-to-back frames under one select
        push_tx(m, 16'h0001);
        sel_low(m);
        xfer(m, FB'($urandom), FB, 1, 16'h0002, -1, hit);
        xfer(m, FB'($urandom), FB, 1, 16'h0003, -1, hit);
        xfer(m, FB'($urandom), FB, 0, '0, -1, hit);
        sel_high(m);
        // Underrun
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
        ferr_cnt[m] = 0;
`endif
        sel_low(m);
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
        check($sformatf("m%0d underrun frame_err pulses", m), ferr_cnt[m], 1);
`endif
        xfer(m, FB'($urandom), FB, 0, '0, -1, hit);
        sel_high(m);
        // Abort after 7 bits, then a clean frame
        prev = rx_data[m];
        push_tx(m, FB'($urandom));
        sel_low(m);
        xfer(m, FB'($urandom), 7, 0, '0, -1, hit);
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
        ferr_cnt[m] = 0;
`endif
        ssel_n[m] = 1'b1;
        cyc(S + 2);
        check($sformatf("m%0d busy after abort", m), busy[m], 0);
        check($sformatf("m%0d miso_oe after abort", m), miso_oe[m], 0);
        cyc(2 * HP);
        check($sformatf("m%0d rx_data kept on abort", m), rx_data[m], prev);
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
        check($sformatf("m%0d abort frame_err pulses", m), ferr_cnt[m], 1);
`endif
        push_tx(m, FB'($urandom));
        sel_low(m);
        xfer(m, FB'($urandom), FB, 0, '0, -1, hit);
        sel_high(m);
        // Reset during bit 9 while a TX word is held
        sel_low(m);
        xfer(m, FB'($urandom), FB, 1, FB'($urandom), 9, hit);
        check($sformatf("m%0d rst tx_ready", m), tx_ready[m], 1);
        check($sformatf("m%0d rst rx_data", m), rx_data[m], 0);
        check($sformatf("m%0d rst rx_valid", m), rx_valid[m], 0);
        check($sformatf("m%0d rst busy", m), busy[m], 0);
        check($sformatf("m%0d rst miso", m), miso[m], 1);
        check($sformatf("m%0d rst miso_oe", m), miso_oe[m], 0);
        cyc(10);
        push_tx(m, FB'($urandom));
        sel_low(m);
        xfer(m, FB'($urandom), FB, 0, '0, -1, hit);
        sel_high(m);
        // Randomised groups of 1..3 frames with random TX supply
        repeat (4) begin
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) push_tx(m, FB'($urandom));
            sel_low(m);
            for (int k = 0; k < n; k++)
                xfer(m, FB'($urandom), FB, (k < n - 1) && ($urandom_range(0, 1) == 1),
                     FB'($urandom), -1, hit);
            sel_high(m);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            ssel_n[m] = 1'b1; sck[m] = (m >= 2); mosi[m] = 1'b0;
            tx_valid[m] = 1'b0; tx_data[m] = '0;
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
            ferr_cnt[m] = 0;
`endif
        end
        fork
            monitor();
            begin
                #900000;
                $display("FAIL timeout: got no finish, expected finish before %0t", $time);
                $fatal(1, "timeout");
            end
        join_none
        cyc(3);
        rst = 1'b0;
        cyc(2);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d reset tx_ready", m), tx_ready[m], 1);
            check($sformatf("m%0d reset rx_data", m), rx_data[m], 0);
            check($sformatf("m%0d reset rx_valid", m), rx_valid[m], 0);
            check($sformatf("m%0d reset busy", m), busy[m], 0);
            check($sformatf("m%0d reset miso", m), miso[m], 1);
            check($sformatf("m%0d reset miso_oe", m), miso_oe[m], 0);
        end
        for (int m = 0; m < 4; m++) run_mode(m);
        cyc(20);
        for (int m = 0; m < 4; m++)
            check($sformatf("m%0d rx_valid strobes outstanding", m), exp_rx[m].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
